// File: rtl/pipeline_if_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC select codes,
// default vectors, the NOP encoding and the fetch FSM state type.
package pipeline_if_pkg;

  localparam logic [2:0] PCSRC_SEQ    = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_JR     = 3'd3;
  localparam logic [2:0] PCSRC_ILLOP  = 3'd4;
  localparam logic [2:0] PCSRC_XADR   = 3'd5;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] DEFAULT_ILLOP_PC = 32'h8000_0004;
  localparam logic [31:0] DEFAULT_XADR_PC  = 32'h8000_0008;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    HELD  = 1'b1
  } if_state_t;

  // Sequential successor: bit 31 is the supervisor bit and never changes;
  // the lower 31 bits wrap on their own.
  function automatic logic [31:0] seq_next_pc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/pipeline_if_pc_next_mux.sv
// Combinational next-PC selection: sequential successor, redirect target and
// whether the ID-stage select code asks for a redirect at all.
module pc_next_mux
  import pipeline_if_pkg::*;
#(
  parameter logic [31:0] ILLOP_PC = DEFAULT_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = DEFAULT_XADR_PC
) (
  input  logic [2:0]  pc_src,
  input  logic        ifid_flush,
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [31:0] con_ba,
  input  logic [25:0] jt,
  input  logic [31:0] id_bus_a,
  output logic [31:0] seq_pc,
  output logic [31:0] target_pc,
  output logic        redirect_sel
);

  // Decode the select code; codes 6 and 7 behave like sequential fetch.
  always_comb begin
    seq_pc       = seq_next_pc(pc);
    target_pc    = seq_pc;
    redirect_sel = 1'b0;
    case (pc_src)
      PCSRC_BRANCH: begin
        target_pc    = con_ba;
        redirect_sel = ifid_flush;
      end
      PCSRC_JUMP: begin
        target_pc    = {id_pc[31:28], jt, 2'b00};
        redirect_sel = 1'b1;
      end
      PCSRC_JR: begin
        target_pc    = id_bus_a;
        redirect_sel = 1'b1;
      end
      PCSRC_ILLOP: begin
        target_pc    = ILLOP_PC;
        redirect_sel = 1'b1;
      end
      PCSRC_XADR: begin
        target_pc    = XADR_PC;
        redirect_sel = 1'b1;
      end
      default: begin
        target_pc    = seq_pc;
        redirect_sel = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_if.sv
// Instruction-fetch stage: owns the PC, the IF/ID register and a one-entry
// skid buffer that catches an instruction returned while ID is stalled.
module pipeline_if
  import pipeline_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] ILLOP_PC = DEFAULT_ILLOP_PC,
  parameter logic [31:0] XADR_PC  = DEFAULT_XADR_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  PCSrc,
  input  logic        IFID_flush,
  input  logic [31:0] ConBA,
  input  logic [25:0] JT,
  input  logic [31:0] ID_BusA,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_instruction,
  output logic        ID_valid
);

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_d, id_instr_d;
  logic        id_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] seq_pc, target_pc;
  logic        redirect_sel, redirect;

  assign imem_addr = pc_q;

  pc_next_mux #(
    .ILLOP_PC (ILLOP_PC),
    .XADR_PC  (XADR_PC)
  ) u_pc_next_mux (
    .pc_src       (PCSrc),
    .ifid_flush   (IFID_flush),
    .pc           (pc_q),
    .id_pc        (ID_PC),
    .con_ba       (ConBA),
    .jt           (JT),
    .id_bus_a     (ID_BusA),
    .seq_pc       (seq_pc),
    .target_pc    (target_pc),
    .redirect_sel (redirect_sel)
  );

  // A redirect only counts when the instruction requesting it is real and not stalled.
  assign redirect = ID_valid && !stall && redirect_sel;

  // Next-state logic: redirect beats stall, stall beats normal fetch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_pc_d     = ID_PC;
    id_instr_d  = ID_instruction;
    id_valid_d  = ID_valid;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (redirect) begin
      pc_d        = target_pc;
      id_instr_d  = NOP_INSTR;
      id_valid_d  = 1'b0;
      buf_pc_d    = 32'h0;
      buf_instr_d = NOP_INSTR;
      state_d     = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (!stall) begin
            if (imem_ready) begin
              id_pc_d    = pc_q;
              id_instr_d = imem_rdata;
              id_valid_d = 1'b1;
              pc_d       = seq_pc;
            end else begin
              id_instr_d = NOP_INSTR;
              id_valid_d = 1'b0;
            end
          end else if (imem_ready) begin
            buf_pc_d    = pc_q;
            buf_instr_d = imem_rdata;
            pc_d        = seq_pc;
            state_d     = HELD;
          end
        end
        HELD: begin
          if (!stall) begin
            id_pc_d    = buf_pc_q;
            id_instr_d = buf_instr_q;
            id_valid_d = 1'b1;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State registers with synchronous active-low reset overriding everything.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q        <= FETCH;
      pc_q           <= RESET_PC;
      ID_PC          <= 32'h0;
      ID_instruction <= NOP_INSTR;
      ID_valid       <= 1'b0;
      buf_pc_q       <= 32'h0;
      buf_instr_q    <= NOP_INSTR;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      ID_PC          <= id_pc_d;
      ID_instruction <= id_instr_d;
      ID_valid       <= id_valid_d;
      buf_pc_q       <= buf_pc_d;
      buf_instr_q    <= buf_instr_d;
    end
  end

endmodule

// File: tb/tb_pipeline_if.sv
// Directed bench for the fetch stage. Instruction memory returns the bitwise
// inverse of the address, so each expected ID_instruction is ~PC.
module tb_pipeline_if;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  PCSrc;
  logic        IFID_flush;
  logic [31:0] ConBA;
  logic [25:0] JT;
  logic [31:0] ID_BusA;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] ID_PC;
  logic [31:0] ID_instruction;
  logic        ID_valid;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [96:0] want;

  pipeline_if dut (
    .clk            (clk),
    .reset          (reset),
    .PCSrc          (PCSrc),
    .IFID_flush     (IFID_flush),
    .ConBA          (ConBA),
    .JT             (JT),
    .ID_BusA        (ID_BusA),
    .stall          (stall),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_ready     (imem_ready),
    .ID_PC          (ID_PC),
    .ID_instruction (ID_instruction),
    .ID_valid       (ID_valid)
  );

  always #5 clk = ~clk;

  assign imem_rdata = ~imem_addr;

  function automatic logic [96:0] got();
    return {imem_addr, ID_PC, ID_instruction, ID_valid};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; PCSrc = 3'd0; IFID_flush = 1'b0; ConBA = 32'h0; JT = 26'h0;
    ID_BusA = 32'h0; stall = 1'b0; imem_ready = 1'b1;
    step(); step();
    want = {32'h8000_0000, 32'h0, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL reset_state got %h want %h", got(), want); end
    PCSrc = 3'd4; stall = 1'b1;
    step();
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL reset_overrides got %h want %h", got(), want); end
    PCSrc = 3'd0; stall = 1'b0;
  endtask

  task automatic test_sequential();
    reset = 1'b1;
    #1;
    want = {32'h8000_0000, 32'h0, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL seq_0 got %h want %h", got(), want); end
    step();
    want = {32'h8000_0004, 32'h8000_0000, ~32'h8000_0000, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL seq_1 got %h want %h", got(), want); end
    step();
    want = {32'h8000_0008, 32'h8000_0004, ~32'h8000_0004, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL seq_2 got %h want %h", got(), want); end
  endtask

  task automatic test_branch();
    PCSrc = 3'd1; IFID_flush = 1'b1; ConBA = 32'h8000_0040;
    step();
    want = {32'h8000_0040, 32'h8000_0004, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL branch_taken got %h want %h", got(), want); end
    PCSrc = 3'd0; IFID_flush = 1'b0;
    step();
    want = {32'h8000_0044, 32'h8000_0040, ~32'h8000_0040, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL branch_after got %h want %h", got(), want); end
    PCSrc = 3'd1; IFID_flush = 1'b0; ConBA = 32'h1234_5678;
    step();
    want = {32'h8000_0048, 32'h8000_0044, ~32'h8000_0044, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL branch_not_taken got %h want %h", got(), want); end
    PCSrc = 3'd0;
  endtask

  task automatic test_stall();
    reset = 1'b0; step(); reset = 1'b1;
    step(); step(); step(); step();
    want = {32'h8000_0010, 32'h8000_000C, ~32'h8000_000C, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL stall_pre got %h want %h", got(), want); end
    stall = 1'b1;
    step();
    want = {32'h8000_0014, 32'h8000_000C, ~32'h8000_000C, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL stall_1 got %h want %h", got(), want); end
    step();
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL stall_2 got %h want %h", got(), want); end
    stall = 1'b0;
    step();
    want = {32'h8000_0014, 32'h8000_0010, ~32'h8000_0010, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL stall_release got %h want %h", got(), want); end
    step();
    want = {32'h8000_0018, 32'h8000_0014, ~32'h8000_0014, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL stall_resume got %h want %h", got(), want); end
  endtask

  task automatic test_jump();
    PCSrc = 3'd3; ID_BusA = 32'h8000_1000;
    step();
    want = {32'h8000_1000, 32'h8000_0014, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL jr got %h want %h", got(), want); end
    PCSrc = 3'd0;
    step();
    want = {32'h8000_1004, 32'h8000_1000, ~32'h8000_1000, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL jr_after got %h want %h", got(), want); end
    PCSrc = 3'd2; JT = 26'h000_0010;
    step();
    want = {32'h8000_0040, 32'h8000_1000, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL jump got %h want %h", got(), want); end
    PCSrc = 3'd0;
    step();
    want = {32'h8000_0044, 32'h8000_0040, ~32'h8000_0040, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL jump_after got %h want %h", got(), want); end
    stall = 1'b1;
    step();
    want = {32'h8000_0048, 32'h8000_0040, ~32'h8000_0040, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL held_enter got %h want %h", got(), want); end
    stall = 1'b0; PCSrc = 3'd4;
    step();
    want = {32'h8000_0004, 32'h8000_0040, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL illop_in_held got %h want %h", got(), want); end
    PCSrc = 3'd0;
    step();
    want = {32'h8000_0008, 32'h8000_0004, ~32'h8000_0004, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL illop_after got %h want %h", got(), want); end
    PCSrc = 3'd5;
    step();
    want = {32'h8000_0008, 32'h8000_0004, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL xadr got %h want %h", got(), want); end
    PCSrc = 3'd0;
    step();
    want = {32'h8000_000C, 32'h8000_0008, ~32'h8000_0008, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL xadr_after got %h want %h", got(), want); end
    PCSrc = 3'd6;
    step();
    want = {32'h8000_0010, 32'h8000_000C, ~32'h8000_000C, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL pcsrc6_seq got %h want %h", got(), want); end
    PCSrc = 3'd2; JT = 26'h0; stall = 1'b1;
    step();
    want = {32'h8000_0014, 32'h8000_000C, ~32'h8000_000C, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL stall_blocks_jump got %h want %h", got(), want); end
    PCSrc = 3'd0; stall = 1'b0;
    step();
    want = {32'h8000_0014, 32'h8000_0010, ~32'h8000_0010, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL held_release got %h want %h", got(), want); end
  endtask

  task automatic test_not_ready();
    imem_ready = 1'b0;
    want = {32'h8000_0014, 32'h8000_0010, 32'h0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL not_ready_%0d got %h want %h", i, got(), want); end
    end
    imem_ready = 1'b1;
    step();
    want = {32'h8000_0018, 32'h8000_0014, ~32'h8000_0014, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL ready_resume got %h want %h", got(), want); end
    stall = 1'b1;
    step();
    reset = 1'b0; PCSrc = 3'd4;
    step();
    want = {32'h8000_0000, 32'h0, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL reset_in_held got %h want %h", got(), want); end
    reset = 1'b1; PCSrc = 3'd0; stall = 1'b0;
    step();
    want = {32'h8000_0004, 32'h8000_0000, ~32'h8000_0000, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL reset_buffer_clear got %h want %h", got(), want); end
  endtask

  task automatic test_wrap();
    PCSrc = 3'd3; ID_BusA = 32'hFFFF_FFFC;
    step();
    want = {32'hFFFF_FFFC, 32'h8000_0000, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL wrap_setup got %h want %h", got(), want); end
    PCSrc = 3'd0;
    step();
    want = {32'h8000_0000, 32'hFFFF_FFFC, 32'h0000_0003, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL wrap_super got %h want %h", got(), want); end
    PCSrc = 3'd3; ID_BusA = 32'h7FFF_FFFC;
    step();
    want = {32'h7FFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b0};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL wrap_user_setup got %h want %h", got(), want); end
    PCSrc = 3'd0;
    step();
    want = {32'h0000_0000, 32'h7FFF_FFFC, 32'h8000_0003, 1'b1};
    n_cmp++; if (got() !== want) begin n_fail++; $display("FAIL wrap_user got %h want %h", got(), want); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_stall();
    test_jump();
    test_not_ready();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
